param_stack: RTL and testbench

- Parametrised LIFO stack, the next generation of the 8-entry push/pop/top-of-stack block used by the processor datapath.
- Adds configurable width and depth, a synchronous reset, a flush, full/empty/count status, and defined push+pop replace semantics.
- Adds sticky overflow/underflow error flags.
- All state updates on the clk rising edge only. Top-of-stack is a registered output, valid the cycle after any change.

---
 rtl/param_stack.sv | 142 ++++++++++++++
 tb/tb_param_stack.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with a registered top-of-stack output.
//
// Parameters
//   WIDTH  data bits per entry
//   DEPTH  number of entries (>= 2)
//   CNT_W  width of count (2**CNT_W > DEPTH)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   push       push push_data this cycle
//   pop        pop the top entry this cycle
//   flush      discard all entries (priority over push/pop)
//   clr_err    clear the sticky overflow/underflow flags
//   push_data  data to push
//   tos_data   registered top-of-stack value, 0 when empty
//   count      number of valid entries
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was dropped because the stack was full
//   underflow  sticky: a pop was dropped because the stack was empty
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] tos_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    below_idx;
  logic             is_empty;
  logic             is_full;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(DEPTH));
  assign top_idx   = AW'(count_q - CNT_W'(1));
  assign below_idx = AW'(count_q - CNT_W'(2));

  always_comb begin
    count_d = count_q;
    tos_d   = tos_q;
    // Clear first, then any new error below re-sets the flag, so set wins.
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    we      = 1'b0;
    waddr   = AW'(count_q);

    if (flush) begin
      count_d = '0;
      tos_d   = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            count_d = count_q + CNT_W'(1);
            tos_d   = push_data;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else if (count_q == CNT_W'(1)) begin
            count_d = '0;
            tos_d   = '0;
          end else begin
            count_d = count_q - CNT_W'(1);
            tos_d   = mem[below_idx];
          end
        end
        2'b11: begin
          we    = 1'b1;
          tos_d = push_data;
          if (is_empty) begin
            // Pop is illegal, but the push still lands in entry 0.
            unf_d   = 1'b1;
            waddr   = '0;
            count_d = CNT_W'(1);
          end else begin
            waddr = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tos_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage has no reset; contents are only read below count.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[waddr] <= push_data;
    end
  end

  assign tos_data  = tos_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, push, pop, flush, clr_err;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] tos_data;
  logic [CNT_W-1:0] count;
  logic             empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .clr_err   (clr_err),
    .push_data (push_data),
    .tos_data  (tos_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    logic       r, pu, po, fl, cl;
    logic [7:0] d;
    int         c;
    logic [7:0] t;
    logic       o, u;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a queue whose back is the top of stack.
  int unsigned m_q[$];
  logic        m_ovf, m_unf;

  task automatic add(input logic r, pu, po, fl, cl, input logic [7:0] d,
                     input int c, input logic [7:0] t, input logic o, u);
    vec_t v;
    v = '{r: r, pu: pu, po: po, fl: fl, cl: cl, d: d, c: c, t: t, o: o, u: u};
    vecs.push_back(v);
  endtask

  task automatic model_step(input logic r, pu, po, fl, cl, input logic [7:0] d);
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (cl) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (fl) begin
        m_q.delete();
      end else if (pu && po) begin
        if (m_q.size() == 0) begin
          m_unf = 1'b1;
          m_q.push_back(int'(d));
        end else begin
          m_q[m_q.size()-1] = int'(d);
        end
      end else if (pu) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(int'(d));
      end else if (po) begin
        if (m_q.size() == 0) m_unf = 1'b1;
        else void'(m_q.pop_back());
      end
    end
  endtask

  task automatic drive(input logic r, pu, po, fl, cl, input logic [7:0] d);
    rst = r; push = pu; pop = po; flush = fl; clr_err = cl; push_data = d;
    @(posedge clk);
    #1;
    model_step(r, pu, po, fl, cl, d);
  endtask

  // Compare all outputs against an expected tuple; empty/full derive from count.
  task automatic check(input string name, input int c, input logic [7:0] t,
                       input logic o, u);
    logic [15:0] act, req;
    act = {count, tos_data, empty, full, overflow, underflow};
    req = {CNT_W'(c), t, (c == 0), (c == DEPTH), o, u};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got count=%0d tos=%02h empty=%b full=%b ovf=%b unf=%b, required count=%0d tos=%02h empty=%b full=%b ovf=%b unf=%b",
               name, count, tos_data, empty, full, overflow, underflow,
               c, t, (c == 0), (c == DEPTH), o, u);
    end
  endtask

  function automatic logic [7:0] model_tos();
    if (m_q.size() == 0) return 8'h00;
    return m_q[m_q.size()-1][7:0];
  endfunction

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    push_data = '0;
    m_ovf = 1'b0; m_unf = 1'b0;

    //   r  pu po fl cl data    cnt tos    o  u
    add(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 0, 0, 8'(i * 8'h11), i, 8'(i * 8'h11), 0, 0);
    add(0, 1, 0, 0, 0, 8'h99, 8, 8'h88, 1, 0);   // overflow
    add(0, 0, 1, 0, 0, 8'h00, 7, 8'h77, 1, 0);
    add(0, 0, 0, 0, 1, 8'h00, 7, 8'h77, 0, 0);   // clr_err
    add(0, 1, 0, 0, 0, 8'h88, 8, 8'h88, 0, 0);   // refill
    for (int i = 7; i >= 0; i--)
      add(0, 0, 1, 0, 0, 8'h00, i, 8'(i * 8'h11), 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);   // underflow
    add(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0, 0, 8'h10, 1, 8'h10, 0, 0);
    add(0, 1, 0, 0, 0, 8'h20, 2, 8'h20, 0, 0);
    add(0, 1, 1, 0, 0, 8'h30, 2, 8'h30, 0, 0);   // replace
    add(0, 0, 1, 0, 0, 8'h00, 1, 8'h10, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 1, 0, 0, 8'h55, 1, 8'h55, 0, 1);   // push+pop on empty
    add(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    add(0, 0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 1);   // clr_err + illegal pop
    add(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0, 0, 8'h01, 1, 8'h01, 0, 0);
    add(0, 1, 0, 0, 0, 8'h02, 2, 8'h02, 0, 0);
    add(0, 1, 0, 0, 0, 8'h03, 3, 8'h03, 0, 0);
    add(0, 1, 0, 1, 0, 8'hAA, 0, 8'h00, 0, 0);   // flush + push
    add(0, 1, 0, 0, 0, 8'h05, 1, 8'h05, 0, 0);
    add(0, 1, 0, 0, 0, 8'h06, 2, 8'h06, 0, 0);
    add(1, 0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);   // rst + pop
    // push+pop on a full stack replaces the top without overflow
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 0, 0, 8'(8'hA0 + i), i, 8'(8'hA0 + i), 0, 0);
    add(0, 1, 1, 0, 0, 8'hC3, 8, 8'hC3, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 7, 8'hA7, 0, 0);
    add(0, 1, 0, 0, 0, 8'hE1, 8, 8'hE1, 0, 0);
    add(0, 1, 0, 0, 0, 8'hE2, 8, 8'hE1, 1, 0);
    add(0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0);   // flush keeps flags
    add(0, 0, 1, 1, 1, 8'h00, 0, 8'h00, 0, 0);   // flush+clr, pop ignored

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].pu, vecs[i].po, vecs[i].fl, vecs[i].cl, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].o, vecs[i].u);
    end

    // Randomised phase against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic r, pu, po, fl, cl;
      logic [7:0] d;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 39) == 0);
      cl = ($urandom_range(0, 11) == 0);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 45);
      d  = 8'($urandom);
      drive(r, pu, po, fl, cl, d);
      check($sformatf("rand%0d", n), m_q.size(), model_tos(), m_ovf, m_unf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
